// File: rtl/gpu_bus_master_if.sv
// Command/response handshake plus the GPU register bus, bundled for gpu_bus_master.
// The master modport is the bus master's view; the slave modport is the host/GPU side.
interface gpu_bus_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [2:0] addr;
    logic       rw;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] data_in;
    logic       cs_clock;

    modport master (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, data_in,
        output cmd_ready, rsp_valid, rsp_data, addr, rw, data_out, data_oe, cs_clock
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, data_in,
        input  cmd_ready, rsp_valid, rsp_data, addr, rw, data_out, data_oe, cs_clock
    );
endinterface

// File: rtl/gpu_bus_master.sv
// GPU register-bus master: IDLE/SETUP/STROBE cycle of HALF clocks per phase, plus irq synchronizer.
// Define GPU_BUS_MASTER_FIFO_EN to put a FIFO_DEPTH-entry command FIFO in front of the FSM.
module gpu_bus_master #(
    parameter int unsigned HALF       = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               CLK100MHz,
    input  logic               rst,
    gpu_bus_master_if.master   bus,
    input  logic               irq,
    output logic               irq_sync,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  phase_q, phase_d;
    logic [2:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic [1:0]  irq_q;
    logic        take;
    logic [11:0] head;
    logic        pending;

    if (HALF < 1 || HALF > 15 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("gpu_bus_master: HALF must be 1..15, FIFO_DEPTH a power of two >= 2");
    end

`ifdef GPU_BUS_MASTER_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [11:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]  cnt_q;
    logic         full, empty, push;

    assign full          = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign empty         = (cnt_q == '0);
    assign bus.cmd_ready = !full && !rst;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign take          = (state_q == IDLE) && !empty;
    assign head          = mem_q[rp_q];
    assign pending       = !empty;

    always_ff @(posedge CLK100MHz) begin
        if (push) mem_q[wp_q] <= {bus.cmd_rw, bus.cmd_addr, bus.cmd_wdata};
    end

    // Pointers are AW bits wide, so wrap-around is the natural overflow.
    always_ff @(posedge CLK100MHz or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wp_q <= wp_q + 1'b1;
            if (take) rp_q <= rp_q + 1'b1;
            case ({push, take})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
`else
    assign bus.cmd_ready = (state_q == IDLE) && !rst;
    assign take          = bus.cmd_valid && bus.cmd_ready;
    assign head          = {bus.cmd_rw, bus.cmd_addr, bus.cmd_wdata};
    assign pending       = 1'b0;
`endif

    always_ff @(posedge CLK100MHz or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b1;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            irq_q       <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            irq_q       <= {irq_q[0], irq};
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d                = SETUP;
                    phase_d                = '0;
                    {rw_d, addr_d, wdata_d} = head;
                end
            end
            SETUP: begin
                if (phase_q == 4'(HALF - 1)) begin
                    state_d = STROBE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            STROBE: begin
                if (phase_q == 4'(HALF - 1)) begin
                    state_d = IDLE;
                    phase_d = '0;
                    if (rw_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = bus.data_in;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobe and output-enable decode straight from state so reset drops them without an edge.
    assign bus.cs_clock  = (state_q == STROBE);
    assign bus.data_oe   = (state_q == STROBE) && !rw_q;
    assign bus.addr      = addr_q;
    assign bus.rw        = rw_q;
    assign bus.data_out  = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state_q != IDLE) || pending;
    assign irq_sync      = irq_q[1];
endmodule

// File: tb/tb_gpu_bus_master.sv
// Directed bench for gpu_bus_master: HALF=4 instance for bus timing/reset/irq, HALF=1 instance for short reads.
// Expected timings shift by one cycle when GPU_BUS_MASTER_FIFO_EN is defined.
module tb_gpu_bus_master;
`ifdef GPU_BUS_MASTER_FIFO_EN
    localparam int D = 1;
`else
    localparam int D = 0;
`endif
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst;
    logic irq;
    logic irq_sync4, irq_sync1, busy4, busy1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    gpu_bus_master_if bus4 ();
    gpu_bus_master_if bus1 ();

    gpu_bus_master #(.HALF(H), .FIFO_DEPTH(4)) u_dut (
        .CLK100MHz (clk),
        .rst       (rst),
        .bus       (bus4),
        .irq       (irq),
        .irq_sync  (irq_sync4),
        .busy      (busy4)
    );

    gpu_bus_master #(.HALF(1), .FIFO_DEPTH(4)) u_dut1 (
        .CLK100MHz (clk),
        .rst       (rst),
        .bus       (bus1),
        .irq       (1'b0),
        .irq_sync  (irq_sync1),
        .busy      (busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One command on the HALF=4 instance; data_in carries din only while strobing.
    task automatic do_cmd(input string nm, input logic r, input logic [2:0] a,
                          input logic [7:0] wd, input logic [7:0] din);
        int first_cs = 0, ncs = 0, noe = 0, nrsp = 0, rsp_at = 0, bad = 0;
        logic [7:0] rd = '0;
        @(negedge clk);
        chk({nm, "_ready"}, bus4.cmd_ready, 1);
        bus4.cmd_valid = 1'b1; bus4.cmd_rw = r; bus4.cmd_addr = a; bus4.cmd_wdata = wd;
        @(posedge clk);
        for (int rel = 1; rel <= 2*H + 3 + D; rel++) begin
            @(negedge clk);
            bus4.cmd_valid = 1'b0;
            if (bus4.cs_clock) begin
                ncs++;
                if (first_cs == 0) first_cs = rel;
                if (bus4.data_oe) noe++;
                if (bus4.addr !== a || bus4.rw !== r || (!r && bus4.data_out !== wd)) bad++;
            end
            if (bus4.rsp_valid) begin
                nrsp++; rsp_at = rel; rd = bus4.rsp_data;
            end
            bus4.data_in = bus4.cs_clock ? din : ~din;
        end
        chk({nm, "_first_cs"}, first_cs, H + 1 + D);
        chk({nm, "_cs_len"}, ncs, H);
        chk({nm, "_oe_len"}, noe, r ? 0 : H);
        chk({nm, "_bus_stable"}, bad, 0);
        chk({nm, "_rsp_count"}, nrsp, r ? 1 : 0);
        if (r) begin
            chk({nm, "_rsp_at"}, rsp_at, 2*H + 1 + D);
            chk({nm, "_rsp_data"}, rd, din);
        end
        chk({nm, "_busy_end"}, busy4, 0);
    endtask

`ifdef GPU_BUS_MASTER_FIFO_EN
    logic [2:0] issued[$];
    logic       cs_prev = 1'b0;
    always @(negedge clk) begin
        if (bus4.cs_clock && !cs_prev) issued.push_back(bus4.addr);
        cs_prev = bus4.cs_clock;
    end
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc[2];
        int nacc, low_run, gap, nrsp;
        logic prev_cs, switched, seen_hi, pend, saw_full;
        logic [7:0] rd;
        int n;

        rst = 1'b1; irq = 1'b0;
        bus4.cmd_valid = 0; bus4.cmd_rw = 0; bus4.cmd_addr = 0; bus4.cmd_wdata = 0; bus4.data_in = 0;
        bus1.cmd_valid = 0; bus1.cmd_rw = 0; bus1.cmd_addr = 0; bus1.cmd_wdata = 0; bus1.data_in = 0;
        #23;
        chk("rst_cs", bus4.cs_clock, 0);
        chk("rst_oe", bus4.data_oe, 0);
        chk("rst_rw", bus4.rw, 1);
        chk("rst_addr", bus4.addr, 0);
        chk("rst_dout", bus4.data_out, 0);
        chk("rst_rsp_valid", bus4.rsp_valid, 0);
        chk("rst_rsp_data", bus4.rsp_data, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_irq_sync", irq_sync4, 0);
        chk("rst_ready", bus4.cmd_ready, 0);
        @(negedge clk); rst = 1'b0;
        chk("idle_rw_held", bus4.rw, 1);

        do_cmd("wr1", 1'b0, 3'd3, 8'hA5, 8'h00);
        chk("idle_dout_held", bus4.data_out, 8'hA5);
        do_cmd("rd1", 1'b1, 3'd5, 8'h00, 8'h3C);
        do_cmd("wr2", 1'b0, 3'd7, 8'h5A, 8'hFF);
        chk("rsp_data_hold", bus4.rsp_data, 8'h3C);
        do_cmd("rd2", 1'b1, 3'd0, 8'h00, 8'hC3);

        // back-to-back write then read with cmd_valid held high
        nacc = 0; low_run = 0; gap = -1; nrsp = 0; rd = '0;
        prev_cs = 0; switched = 0; seen_hi = 0;
        @(negedge clk);
        bus4.cmd_valid = 1; bus4.cmd_rw = 0; bus4.cmd_addr = 3'd2; bus4.cmd_wdata = 8'h11;
        for (int i = 0; i < 40; i++) begin
            if (bus4.cmd_valid && bus4.cmd_ready && nacc < 2) begin
                acc[nacc] = cyc + 1; nacc++;
            end
            @(negedge clk);
            if (nacc == 1 && !switched) begin
                bus4.cmd_rw = 1; bus4.cmd_addr = 3'd6; switched = 1;
            end
            if (nacc == 2) bus4.cmd_valid = 0;
            if (bus4.cs_clock && !prev_cs && seen_hi) gap = low_run;
            if (bus4.cs_clock) begin seen_hi = 1; low_run = 0; end
            else low_run++;
            prev_cs = bus4.cs_clock;
            if (bus4.rsp_valid) begin nrsp++; rd = bus4.rsp_data; end
            bus4.data_in = bus4.cs_clock ? 8'h77 : 8'h88;
        end
        chk("b2b_accepts", nacc, 2);
        chk("b2b_spacing", acc[1] - acc[0], D ? 1 : 2*H + 1);
        chk("b2b_cs_gap", gap, H + 1);
        chk("b2b_rsp_count", nrsp, 1);
        chk("b2b_rsp_data", rd, 8'h77);
        chk("b2b_busy_end", busy4, 0);

        // reset asserted in the middle of a read strobe
        @(negedge clk);
        bus4.cmd_valid = 1; bus4.cmd_rw = 1; bus4.cmd_addr = 3'd1;
        @(posedge clk);
        @(negedge clk); bus4.cmd_valid = 0;
        n = 0;
        while (!bus4.cs_clock && n < 20) begin @(negedge clk); n++; end
        chk("rst_mid_reached_strobe", bus4.cs_clock, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_cs", bus4.cs_clock, 0);
        chk("rst_mid_oe", bus4.data_oe, 0);
        chk("rst_mid_busy", busy4, 0);
        chk("rst_mid_rsp", bus4.rsp_valid, 0);
        chk("rst_mid_ready", bus4.cmd_ready, 0);
        @(negedge clk); @(negedge clk);
        chk("rst_mid_rsp_later", bus4.rsp_valid, 0);
        rst = 1'b0;
        bus4.cmd_valid = 1; bus4.cmd_rw = 0; bus4.cmd_addr = 3'd4; bus4.cmd_wdata = 8'h42;
        @(posedge clk); #1;
        chk("post_rst_accept", busy4, 1);
        @(negedge clk); bus4.cmd_valid = 0;
        nrsp = 0;
        for (int i = 0; i < 2*H + 4; i++) begin
            @(negedge clk);
            if (bus4.rsp_valid) nrsp++;
        end
        chk("post_rst_no_rsp", nrsp, 0);
        chk("post_rst_busy_end", busy4, 0);

        // irq synchronizer: two rising edges of latency
        @(negedge clk); #1 irq = 1'b1;
        @(posedge clk); #1 chk("irq_rise_1edge", irq_sync4, 0);
        @(posedge clk); #1 chk("irq_rise_2edge", irq_sync4, 1);
        #3 irq = 1'b0;
        @(posedge clk); #1 chk("irq_fall_1edge", irq_sync4, 1);
        @(posedge clk); #1 chk("irq_fall_2edge", irq_sync4, 0);

        // HALF=1 read
        @(negedge clk);
        bus1.cmd_valid = 1; bus1.cmd_rw = 1; bus1.cmd_addr = 3'd2; bus1.data_in = 8'h5A;
        @(posedge clk);
        n = 0; nrsp = 0; rd = '0;
        for (int rel = 1; rel <= 6; rel++) begin
            @(negedge clk);
            bus1.cmd_valid = 0;
            if (bus1.rsp_valid) begin nrsp++; n = rel; rd = bus1.rsp_data; end
        end
        chk("h1_rsp_count", nrsp, 1);
        chk("h1_rsp_at", n, 3 + D);
        chk("h1_rsp_data", rd, 8'h5A);
        chk("h1_busy_end", busy1, 0);

`ifdef GPU_BUS_MASTER_FIFO_EN
        // six writes pushed as fast as ready allows; issue order must match
        issued.delete();
        n = 0; pend = 0; saw_full = 0;
        for (int i = 0; i < 200 && (n < 6 || busy4); i++) begin
            @(negedge clk);
            if (pend) n++;
            if (n < 6) begin
                bus4.cmd_valid = 1; bus4.cmd_rw = 0;
                bus4.cmd_addr = 3'(n + 1); bus4.cmd_wdata = 8'(n);
                pend = bus4.cmd_ready;
                if (!bus4.cmd_ready) saw_full = 1;
            end else begin
                bus4.cmd_valid = 0; pend = 0;
            end
        end
        chk("fifo_saw_full", saw_full, 1);
        chk("fifo_issued", issued.size(), 6);
        for (int k = 0; k < 6 && k < issued.size(); k++)
            chk($sformatf("fifo_order_%0d", k), issued[k], k + 1);
        chk("fifo_busy_end", busy4, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
